pt_write_buffer: RTL and testbench

Downstream stage of `projective_transform`: captures each transformed pixel (`pt_wr`, `pt_x`, `pt_y`, `pt_pixel_write`), converts the coordinate into a linear frame-buffer address, and queues address/data pairs in a small FIFO. The FIFO drains into the ZBT memory arbiter through a req/ack handshake. It applies backpressure to the transform through `pt_stall`, and double-buffers frames by bank select.

---
 rtl/pt_pkg.sv | 33 +++
 rtl/pt_fifo.sv | 60 ++++++
 rtl/pt_write_buffer.sv | 97 +++++++++
 tb/tb_pt_write_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// pt_pkg: shared constants, entry type and address helper for the projective-transform pixel path
//   H_RES/V_RES  : active frame size
//   PIX_W/X_W/Y_W: pixel and coordinate widths
//   ADDR_W       : linear in-bank frame-buffer address width
//   pt_entry_t   : queued write {bank, addr, pixel}
package pt_pkg;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int PIX_W  = 18;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int ADDR_W = 19;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pixel;
    } pt_entry_t;

    // 640 = 512 + 128, so the common case becomes two shifts and an add
    function automatic logic [ADDR_W-1:0] pt_lin_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int unsigned    hres
    );
        logic [ADDR_W-1:0] w_x;
        logic [ADDR_W-1:0] w_y;
        w_x = ADDR_W'(x);
        w_y = ADDR_W'(y);
        return (hres == 640) ? (w_y << 9) + (w_y << 7) + w_x
                             : w_y * ADDR_W'(hres) + w_x;
    endfunction
endpackage

// File: rtl/pt_fifo.sv
// pt_fifo: generic synchronous first-word-fall-through FIFO
//   clk, reset_n      : clock, synchronous active-low reset
//   push, wr_data     : write request and data (ignored when full unless popping)
//   pop               : consume head (ignored when empty)
//   rd_data           : current head entry
//   full, empty, count: registered occupancy status
module pt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_next;

    assign w_pop        = pop && !r_empty;
    // a full FIFO still accepts a write when the head leaves on the same edge
    assign w_push       = push && (!r_full || w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= w_count_next;
            r_full   <= w_count_next == CW'(DEPTH);
            r_empty  <= w_count_next == '0;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = r_empty;
    assign count   = r_count;
endmodule

// File: rtl/pt_write_buffer.sv
// pt_write_buffer: range-checks transformed pixels, converts them to frame-buffer addresses and queues them for the ZBT arbiter
//   clk, reset_n                 : clock, synchronous active-low reset
//   frame_flag                   : new-frame pulse (toggles bank, clears overflow/drop_count)
//   pt_wr, pt_x, pt_y, pt_pixel_write : incoming pixel
//   pt_stall                     : backpressure to the transform
//   mem_req, mem_addr, mem_data, mem_ack : write handshake to the arbiter
//   overflow, drop_count, bank   : status
module pt_write_buffer #(
    parameter int DEPTH = 16,
    parameter int H_RES = pt_pkg::H_RES,
    parameter int V_RES = pt_pkg::V_RES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_flag,
    input  logic                      pt_wr,
    input  logic [pt_pkg::X_W-1:0]    pt_x,
    input  logic [pt_pkg::Y_W-1:0]    pt_y,
    input  logic [pt_pkg::PIX_W-1:0]  pt_pixel_write,
    output logic                      pt_stall,
    output logic                      mem_req,
    output logic [pt_pkg::ADDR_W:0]   mem_addr,
    output logic [pt_pkg::PIX_W-1:0]  mem_data,
    input  logic                      mem_ack,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic                      bank
);
    import pt_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    pt_entry_t     r_a_entry;
    logic          r_a_valid;
    logic          r_bank;
    logic          r_overflow;
    logic [15:0]   r_drop;
    logic          r_stall;
    pt_entry_t     w_head;
    logic          w_in_range;
    logic          w_new_bank;
    logic          w_pop;
    logic          w_lost;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    // a pixel arriving with frame_flag belongs to the new frame
    assign w_new_bank = r_bank ^ frame_flag;
    assign w_in_range = (32'(pt_x) < H_RES) && (32'(pt_y) < V_RES);
    assign w_pop      = !w_empty && mem_ack;
    assign w_lost     = r_a_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_valid  <= 1'b0;
            r_a_entry  <= '0;
            r_bank     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_a_valid  <= pt_wr && w_in_range;
            if (pt_wr && w_in_range)
                r_a_entry <= '{bank: w_new_bank, addr: pt_lin_addr(pt_x, pt_y, H_RES), pixel: pt_pixel_write};
            r_bank     <= w_new_bank;
            r_overflow <= frame_flag ? 1'b0 : (r_overflow || w_lost);
            r_drop     <= frame_flag ? '0
                        : (pt_wr && !w_in_range && r_drop != 16'hFFFF) ? r_drop + 16'd1 : r_drop;
            // two slots of headroom cover the stage-A entry and the pixel sampled alongside
            r_stall    <= w_count >= CW'(DEPTH - 2);
        end
    end

    pt_fifo #(
        .W     ($bits(pt_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (r_a_valid),
        .pop     (w_pop),
        .wr_data (r_a_entry),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign pt_stall   = r_stall;
    assign mem_req    = !w_empty;
    assign mem_addr   = {w_head.bank, w_head.addr};
    assign mem_data   = w_head.pixel;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign bank       = r_bank;
endmodule

// File: tb/tb_pt_write_buffer.sv
// tb_pt_write_buffer: directed self-checking bench for pt_write_buffer
module tb_pt_write_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_flag;
    logic        pt_wr;
    logic [9:0]  pt_x;
    logic [8:0]  pt_y;
    logic [17:0] pt_pixel_write;
    logic        pt_stall;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic [17:0] mem_data;
    logic        mem_ack;
    logic        overflow;
    logic [15:0] drop_count;
    logic        bank;

    int n_total = 0;
    int n_pass  = 0;

    pt_write_buffer #(.DEPTH(16), .H_RES(640), .V_RES(480)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_flag     (frame_flag),
        .pt_wr          (pt_wr),
        .pt_x           (pt_x),
        .pt_y           (pt_y),
        .pt_pixel_write (pt_pixel_write),
        .pt_stall       (pt_stall),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ack        (mem_ack),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .bank           (bank)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pix(input int x, input int y, input int p);
        pt_wr = 1'b1;
        pt_x = 10'(x);
        pt_y = 9'(y);
        pt_pixel_write = 18'(p);
    endtask

    initial begin
        logic [19:0] ea;
        reset_n = 1'b0; frame_flag = 1'b0; pt_wr = 1'b0; pt_x = '0; pt_y = '0;
        pt_pixel_write = '0; mem_ack = 1'b0;
        cyc(); cyc();
        chk("rst_req", mem_req, 0);
        chk("rst_stall", pt_stall, 0);
        chk("rst_bank", bank, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        reset_n = 1'b1;
        cyc();

        // single pixel latency and handshake
        pix(5, 2, 'h2AAAA);
        cyc();
        pt_wr = 1'b0;
        chk("lat_req_early", mem_req, 0);
        cyc();
        chk("lat_req", mem_req, 1);
        chk("lat_addr", mem_addr, 1285);
        chk("lat_data", mem_data, 'h2AAAA);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("lat_pop", mem_req, 0);

        // corner addresses and range drops
        pix(639, 479, 1);
        cyc();
        pix(640, 0, 2);
        cyc();
        pix(0, 480, 3);
        cyc();
        pt_wr = 1'b0;
        chk("corner_addr", mem_addr, 307199);
        chk("corner_data", mem_data, 1);
        chk("corner_drop", drop_count, 2);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        cyc();
        chk("corner_noreq", mem_req, 0);

        // overflow with ack held low
        for (int i = 0; i < 20; i++) begin
            pix(i, 10, 'h100 + i);
            cyc();
            if (i == 14) chk("stall_c14", pt_stall, 0);
            if (i == 15) chk("stall_c15", pt_stall, 1);
        end
        pt_wr = 1'b0;
        cyc();
        chk("ovf_set", overflow, 1);
        chk("ovf_stall", pt_stall, 1);
        mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_req", mem_req, 1);
            chk("drain_addr", mem_addr, 6400 + i);
            chk("drain_data", mem_data, 'h100 + i);
            cyc();
        end
        mem_ack = 1'b0;
        chk("drain_empty", mem_req, 0);
        cyc();
        chk("drain_unstall", pt_stall, 0);

        // frame switch with entries already queued
        for (int i = 0; i < 3; i++) begin
            pix(i, 0, 'h3000 + i);
            cyc();
        end
        pt_wr = 1'b0;
        cyc();
        frame_flag = 1'b1;
        cyc();
        frame_flag = 1'b0;
        chk("ff_bank", bank, 1);
        chk("ff_ovf_clr", overflow, 0);
        chk("ff_drop_clr", drop_count, 0);
        for (int i = 0; i < 2; i++) begin
            pix(10 + i, 1, 'h3100 + i);
            cyc();
        end
        pt_wr = 1'b0;
        cyc();
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ff_old_addr", mem_addr, i);
            chk("ff_old_data", mem_data, 'h3000 + i);
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            chk("ff_new_addr", mem_addr, 'h80000 + 650 + i);
            chk("ff_new_data", mem_data, 'h3100 + i);
            cyc();
        end
        chk("ff_empty", mem_req, 0);

        // streaming burst with ack held high; frame_flag mid-burst
        for (int i = 0; i < 100; i++) begin
            pix(i, 3, i);
            frame_flag = (i == 50);
            cyc();
            if (i > 0) begin
                ea = 20'(1920 + i - 1) | ((i - 1 < 50) ? 20'h80000 : 20'h0);
                chk("burst_req", mem_req, 1);
                chk("burst_addr", mem_addr, ea);
                chk("burst_stall", pt_stall, 0);
            end
        end
        pt_wr = 1'b0;
        frame_flag = 1'b0;
        cyc();
        chk("burst_last", mem_addr, 1920 + 99);
        chk("burst_last_data", mem_data, 99);
        cyc();
        chk("burst_done", mem_req, 0);
        chk("burst_bank", bank, 0);
        mem_ack = 1'b0;

        // mid-frame reset with 8 queued entries
        for (int i = 0; i < 8; i++) begin
            pix(i, 5, 'h500 + i);
            frame_flag = (i == 0);
            cyc();
        end
        pt_wr = 1'b0;
        frame_flag = 1'b0;
        cyc();
        chk("pre_rst_bank", bank, 1);
        chk("pre_rst_addr", mem_addr, 'h80000 + 3200);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_bank", bank, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_stall", pt_stall, 0);
        mem_ack = 1'b1;
        pix(7, 7, 'h777);
        cyc();
        pt_wr = 1'b0;
        cyc();
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 4487);
        chk("post_rst_data", mem_data, 'h777);
        cyc();
        mem_ack = 1'b0;
        chk("post_rst_empty", mem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
